// File: rtl/mrjong_load_pkg.sv
// Shared constants, types and the byte-address decoder for the Mr. Jong ROM loader.
package mrjong_load_pkg;

  localparam logic [16:0] CPU_BASE  = 17'h00000;
  localparam logic [16:0] CPU_SIZE  = 17'h08000;
  localparam logic [16:0] GFX_BASE  = 17'h08000;
  localparam logic [16:0] GFX_SIZE  = 17'h04000;
  localparam logic [16:0] PROM_BASE = 17'h0C000;
  localparam logic [16:0] PROM_SIZE = 17'h00120;

  localparam int unsigned HOLD_CYCLES_DEF = 64;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_DIP = 8'd254;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } load_state_t;

  typedef enum logic [1:0] {
    RGN_NONE = 2'd0,
    RGN_CPU  = 2'd1,
    RGN_GFX  = 2'd2,
    RGN_PROM = 2'd3
  } region_t;

  typedef struct packed {
    region_t     region;
    logic [14:0] offset;
  } decode_t;

  // Subtract-then-compare: an address below a base wraps to a large value,
  // so a single unsigned compare checks both ends of the window.
  function automatic decode_t decode_addr(input logic [16:0] a);
    decode_t     r;
    logic [16:0] d_cpu;
    logic [16:0] d_gfx;
    logic [16:0] d_prom;
    d_cpu    = a - CPU_BASE;
    d_gfx    = a - GFX_BASE;
    d_prom   = a - PROM_BASE;
    r.region = RGN_NONE;
    r.offset = 15'd0;
    if (d_cpu < CPU_SIZE) begin
      r.region = RGN_CPU;
      r.offset = d_cpu[14:0];
    end else if (d_gfx < GFX_SIZE) begin
      r.region = RGN_GFX;
      r.offset = d_gfx[14:0];
    end else if (d_prom < PROM_SIZE) begin
      r.region = RGN_PROM;
      r.offset = d_prom[14:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/load_reset_hold.sv
// Holds the core in reset while a ROM download is active and for HOLD_CYCLES
// cycles after it ends (and after the loader itself leaves reset).
module load_reset_hold
  import mrjong_load_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dl_active,
  output logic core_reset_n
);

  localparam int CW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // Reloading on every active cycle makes the falling edge of the download
  // the start of the count: the first inactive cycle sees the full value.
  always_comb begin
    cnt_d = cnt_q;
    if (dl_active) begin
      cnt_d = HOLD_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    done_d = ~dl_active && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= HOLD_LOAD;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Gating with the live condition keeps the core in reset from the very
  // first cycle of a new download, not one cycle later.
  assign core_reset_n = done_q & ~dl_active;

endmodule

// File: rtl/mrjong_rom_loader.sv
// Mr. Jong ROM loader: splits 16-bit HPS download words into two byte writes
// routed to CPU ROM, graphics ROM or colour PROM, and captures the DIP byte.
module mrjong_rom_loader
  import mrjong_load_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic [14:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        cpu_we,
  output logic        gfx_we,
  output logic        prom_we,
  output logic [7:0]  dsw,
  output logic        core_reset_n,
  output logic        busy
);

  // Handshake: ioctl_wr is a single-cycle valid; the loader is ready only in
  // IDLE. ioctl_wait is high while not ready, and a word offered then is
  // dropped without touching the latched word or the state.

  load_state_t state_q, state_d;
  logic [16:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        oor_q, oor_d;
  logic        cpu_we_q, cpu_we_d;
  logic        gfx_we_q, gfx_we_d;
  logic        prom_we_q, prom_we_d;
  logic [14:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic        wait_q, wait_d;
  logic        busy_q, busy_d;
  logic [7:0]  dsw_q, dsw_d;

  logic        dl_active;
  logic        word_start;
  logic        dip_wr;
  logic        issue;
  logic        byte_ok;
  logic [16:0] byte_addr;
  logic [7:0]  byte_data;
  decode_t     dec;

  assign dl_active  = ioctl_download && (ioctl_index == IDX_ROM);
  assign word_start = ioctl_wr && dl_active;
  assign dip_wr     = ioctl_wr && (ioctl_index == IDX_DIP) &&
                      (ioctl_addr[26:3] == 24'd0) && (ioctl_addr[2:0] == 3'd0);

  // Strobes are computed from the byte about to be issued so that they are
  // registered and appear in the same cycle the FSM enters WR_LO / WR_HI.
  // An out-of-range word still walks the FSM; only its strobes are suppressed.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    oor_d     = oor_q;
    issue     = 1'b0;
    byte_ok   = 1'b0;
    byte_addr = 17'd0;
    byte_data = 8'd0;
    case (state_q)
      IDLE: begin
        if (word_start) begin
          state_d   = WR_LO;
          addr_d    = ioctl_addr[16:0];
          data_d    = ioctl_dout;
          oor_d     = |ioctl_addr[26:17];
          issue     = 1'b1;
          byte_ok   = ~|ioctl_addr[26:17];
          byte_addr = ioctl_addr[16:0];
          byte_data = ioctl_dout[7:0];
        end
      end
      WR_LO: begin
        state_d   = WR_HI;
        issue     = 1'b1;
        byte_ok   = ~oor_q;
        byte_addr = addr_q + 17'd1;
        byte_data = data_q[15:8];
      end
      WR_HI: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    dec        = decode_addr(byte_addr);
    cpu_we_d   = issue && byte_ok && (dec.region == RGN_CPU);
    gfx_we_d   = issue && byte_ok && (dec.region == RGN_GFX);
    prom_we_d  = issue && byte_ok && (dec.region == RGN_PROM);
    rom_addr_d = issue ? dec.offset : rom_addr_q;
    rom_data_d = issue ? byte_data : rom_data_q;
    wait_d     = (state_d != IDLE);
    busy_d     = (state_d != IDLE);
    dsw_d      = dip_wr ? ioctl_dout[7:0] : dsw_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= 17'd0;
      data_q     <= 16'd0;
      oor_q      <= 1'b0;
      cpu_we_q   <= 1'b0;
      gfx_we_q   <= 1'b0;
      prom_we_q  <= 1'b0;
      rom_addr_q <= 15'd0;
      rom_data_q <= 8'd0;
      wait_q     <= 1'b0;
      busy_q     <= 1'b0;
      dsw_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      oor_q      <= oor_d;
      cpu_we_q   <= cpu_we_d;
      gfx_we_q   <= gfx_we_d;
      prom_we_q  <= prom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      dsw_q      <= dsw_d;
    end
  end

  load_reset_hold #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk          (clk_sys),
    .rst_n        (reset_n),
    .dl_active    (dl_active),
    .core_reset_n (core_reset_n)
  );

  assign ioctl_wait = wait_q;
  assign busy       = busy_q;
  assign cpu_we     = cpu_we_q;
  assign gfx_we     = gfx_we_q;
  assign prom_we    = prom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign dsw        = dsw_q;

endmodule

// File: tb/tb_mrjong_rom_loader.sv
// Bench for mrjong_rom_loader: directed words, DIP writes, reset-hold timing
// and async reset, checked against a cycle-indexed behavioural model.
module tb_mrjong_rom_loader;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic        cpu_we;
  logic        gfx_we;
  logic        prom_we;
  logic [7:0]  dsw;
  logic        core_reset_n;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Expected byte writes: {cycle[15:0], we{prom,gfx,cpu}[2:0], offset[14:0], data[7:0]}
  logic [41:0] exp_q[$];
  int          free_cyc = 0;
  int          wait_lo  = 1;
  int          wait_hi  = 0;
  int          quiet    = 0;
  logic [7:0]  dsw_exp  = 8'h00;

  mrjong_rom_loader dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .cpu_we         (cpu_we),
    .gfx_we         (gfx_we),
    .prom_we        (prom_we),
    .dsw            (dsw),
    .core_reset_n   (core_reset_n),
    .busy           (busy)
  );

  // Clock / reset
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model
  function automatic void model_reset();
    exp_q.delete();
    free_cyc = 0;
    wait_lo  = 1;
    wait_hi  = 0;
    quiet    = 0;
    dsw_exp  = 8'h00;
  endfunction

  function automatic void push_byte(input int at, input logic [16:0] a, input logic [7:0] d);
    logic [2:0]  we;
    logic [16:0] off;
    we  = 3'b000;
    off = 17'd0;
    if (a < 17'h08000) begin
      we = 3'b001; off = a;
    end else if (a < 17'h0C000) begin
      we = 3'b010; off = a - 17'h08000;
    end else if (a < 17'h0C120) begin
      we = 3'b100; off = a - 17'h0C000;
    end
    if (we != 3'b000) exp_q.push_back({16'(at), we, off[14:0], d});
  endfunction

  always @(posedge clk_sys) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      if (ioctl_wr && ioctl_download && ioctl_index == 8'd0 && cyc >= free_cyc) begin
        free_cyc = cyc + 3;
        wait_lo  = cyc + 1;
        wait_hi  = cyc + 2;
        if (ioctl_addr[26:17] == 10'd0) begin
          push_byte(cyc + 1, ioctl_addr[16:0], ioctl_dout[7:0]);
          push_byte(cyc + 2, ioctl_addr[16:0] + 17'd1, ioctl_dout[15:8]);
        end
      end
      if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr == 27'd0) dsw_exp = ioctl_dout[7:0];
      if (ioctl_download && ioctl_index == 8'd0) quiet = 0;
      else quiet++;
    end
    cyc++;
  end

  // Scoreboard compare, every cycle at the falling edge
  always @(negedge clk_sys) begin : cmp_blk
    logic [41:0] e;
    logic [2:0]  we_e;
    logic [14:0] a_e;
    logic [7:0]  d_e;
    logic        w_e;
    logic        crn_e;
    we_e = 3'b000;
    a_e  = 15'd0;
    d_e  = 8'd0;
    if (exp_q.size() > 0 && exp_q[0][41:26] == 16'(cyc)) begin
      e    = exp_q.pop_front();
      we_e = e[25:23];
      a_e  = e[22:8];
      d_e  = e[7:0];
    end
    check("sb_cpu_we", cpu_we, we_e[0]);
    check("sb_gfx_we", gfx_we, we_e[1]);
    check("sb_prom_we", prom_we, we_e[2]);
    if (we_e != 3'b000) begin
      check("sb_rom_addr", rom_addr, a_e);
      check("sb_rom_data", rom_data, d_e);
    end
    w_e = reset_n && (cyc >= wait_lo) && (cyc <= wait_hi);
    check("sb_wait", ioctl_wait, w_e);
    check("sb_busy", busy, w_e);
    check("sb_dsw", dsw, dsw_exp);
    crn_e = reset_n && !(ioctl_download && ioctl_index == 8'd0) && (quiet >= 64);
    check("sb_core_reset_n", core_reset_n, crn_e);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic word_check(input logic [26:0] a, input logic [15:0] d, input logic [2:0] we_e,
                            input logic [14:0] lo_off, input logic [7:0] lo_d,
                            input logic [7:0] hi_d, input bit drop_dl);
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b1;
    ioctl_addr     = a;
    ioctl_dout     = d;
    step();
    ioctl_wr = 1'b0;
    if (drop_dl) ioctl_download = 1'b0;
    #1;
    check("lo_we", {prom_we, gfx_we, cpu_we}, we_e);
    check("lo_wait", ioctl_wait, 1);
    if (we_e != 3'b000) begin
      check("lo_addr", rom_addr, lo_off);
      check("lo_data", rom_data, lo_d);
    end
    step();
    #1;
    check("hi_we", {prom_we, gfx_we, cpu_we}, we_e);
    check("hi_wait", ioctl_wait, 1);
    if (we_e != 3'b000) begin
      check("hi_addr", rom_addr, lo_off + 15'd1);
      check("hi_data", rom_data, hi_d);
    end
    step();
    #1;
    check("idle_we", {prom_we, gfx_we, cpu_we}, 0);
    check("idle_wait", ioctl_wait, 0);
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 27'd0;
    ioctl_dout     = 16'd0;
    repeat (3) step();
    #1;
    check("rst_we", {prom_we, gfx_we, cpu_we}, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_busy", busy, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_rom_data", rom_data, 0);
    check("rst_dsw", dsw, 0);
    check("rst_core_reset_n", core_reset_n, 0);

    // Release: core_reset_n rises 64 cycles later
    step();
    reset_n = 1'b1;
    repeat (63) step();
    #1 check("rel_hold_63", core_reset_n, 0);
    step();
    #1 check("rel_hold_64", core_reset_n, 1);

    // Words, issued back to back at one word per 3 cycles
    word_check(27'h0000000, 16'hBEEF, 3'b001, 15'h0000, 8'hEF, 8'hBE, 1'b0);
    word_check(27'h0008002, 16'h1234, 3'b010, 15'h0002, 8'h34, 8'h12, 1'b0);
    word_check(27'h000C11E, 16'h5A6B, 3'b100, 15'h011E, 8'h6B, 8'h5A, 1'b0);
    word_check(27'h000C120, 16'h7788, 3'b000, 15'h0000, 8'h00, 8'h00, 1'b0);
    word_check(27'h0007FFE, 16'hCAFE, 3'b001, 15'h7FFE, 8'hFE, 8'hCA, 1'b0);
    word_check(27'h000BFFE, 16'h0102, 3'b010, 15'h3FFE, 8'h02, 8'h01, 1'b0);
    word_check(27'h0020000, 16'h3344, 3'b000, 15'h0000, 8'h00, 8'h00, 1'b0);
    word_check(27'h0000100, 16'h9876, 3'b001, 15'h0100, 8'h76, 8'h98, 1'b1);

    // Second write while busy is ignored
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 27'h0000010;
    ioctl_dout     = 16'h1111;
    step();
    ioctl_addr = 27'h0000020;
    ioctl_dout = 16'h2222;
    #1;
    check("viol_lo_we", cpu_we, 1);
    check("viol_lo_addr", rom_addr, 15'h0010);
    check("viol_lo_data", rom_data, 8'h11);
    step();
    ioctl_wr = 1'b0;
    #1;
    check("viol_hi_we", cpu_we, 1);
    check("viol_hi_addr", rom_addr, 15'h0011);
    check("viol_hi_data", rom_data, 8'h11);
    step();
    #1;
    check("viol_after_we", {prom_we, gfx_we, cpu_we}, 0);
    check("viol_after_wait", ioctl_wait, 0);
    ioctl_download = 1'b0;

    // DIP switch capture
    ioctl_index = 8'd254;
    ioctl_wr    = 1'b1;
    ioctl_addr  = 27'd0;
    ioctl_dout  = 16'h00A5;
    step();
    ioctl_wr = 1'b0;
    #1;
    check("dip_a5", dsw, 8'hA5);
    check("dip_wait", ioctl_wait, 0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 27'd8;
    ioctl_dout = 16'h003C;
    step();
    ioctl_wr = 1'b0;
    #1;
    check("dip_addr8", dsw, 8'hA5);
    check("dip_addr8_wait", ioctl_wait, 0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 27'd0;
    ioctl_dout = 16'h125A;
    step();
    ioctl_wr = 1'b0;
    #1 check("dip_5a", dsw, 8'h5A);
    ioctl_index = 8'd0;

    // Reset hold after a 40-cycle download
    ioctl_download = 1'b1;
    repeat (40) step();
    #1 check("hold_during_dl", core_reset_n, 0);
    ioctl_download = 1'b0;
    repeat (63) step();
    #1 check("hold_63", core_reset_n, 0);
    step();
    #1 check("hold_64", core_reset_n, 1);

    // Re-asserting the download mid-count restarts the hold
    ioctl_download = 1'b1;
    repeat (40) step();
    ioctl_download = 1'b0;
    repeat (30) step();
    #1 check("restart_mid", core_reset_n, 0);
    ioctl_download = 1'b1;
    repeat (5) step();
    #1 check("restart_dl", core_reset_n, 0);
    ioctl_download = 1'b0;
    repeat (63) step();
    #1 check("restart_63", core_reset_n, 0);
    step();
    #1 check("restart_64", core_reset_n, 1);

    // Asynchronous reset in WR_LO
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 27'h0000040;
    ioctl_dout     = 16'hABCD;
    step();
    ioctl_wr = 1'b0;
    #1 check("arst_pre_we", cpu_we, 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("arst_we", {prom_we, gfx_we, cpu_we}, 0);
    check("arst_wait", ioctl_wait, 0);
    check("arst_busy", busy, 0);
    check("arst_rom_addr", rom_addr, 0);
    repeat (2) step();
    reset_n        = 1'b1;
    ioctl_download = 1'b0;
    repeat (6) step();
    #1;
    check("arst_after_we", {prom_we, gfx_we, cpu_we}, 0);
    check("arst_after_dsw", dsw, 0);
    check("arst_after_crn", core_reset_n, 0);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
